if_fetch: RTL

Instruction-fetch stage that sits directly downstream of the PC register.
- Samples the current PC, reads four bytes through the shared byte-wide memory port, and assembles a little-endian 32-bit instruction.
- Presents the instruction and its PC to the IF/ID latch.
- Raises a stall request while a fetch is in progress, so the PC register and the upstream pipeline hold.
- Branch redirects from ID/EX kill any in-flight fetch.

---
 rtl/if_fetch_if.sv | 35 +++
 rtl/if_fetch.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/if_fetch_if.sv
`default_nettype none
//============================================================================
// Module   : if_fetch_if
// Brief    : PC input, byte-wide memory port and IF/ID handoff of the fetch stage.
// Revision : 1.0
//============================================================================
interface if_fetch_if #(
    parameter int ADDR_W     = 32,
    parameter int INST_BYTES = 4
) ();
    logic [ADDR_W-1:0]       pc_i;
    logic                    branch_flush_i;
    logic                    stall_i;
    logic                    mem_busy_i;
    logic                    mem_req_o;
    logic [ADDR_W-1:0]       mem_addr_o;
    logic [7:0]              mem_rdata_i;
    logic                    mem_rvalid_i;
    logic [8*INST_BYTES-1:0] inst_o;
    logic [ADDR_W-1:0]       inst_pc_o;
    logic                    inst_valid_o;
    logic                    stallreq_o;

    // master is the fetch stage itself; slave is the surrounding pipeline/memory
    modport master (
        input  pc_i, branch_flush_i, stall_i, mem_busy_i, mem_rdata_i, mem_rvalid_i,
        output mem_req_o, mem_addr_o, inst_o, inst_pc_o, inst_valid_o, stallreq_o
    );

    modport slave (
        output pc_i, branch_flush_i, stall_i, mem_busy_i, mem_rdata_i, mem_rvalid_i,
        input  mem_req_o, mem_addr_o, inst_o, inst_pc_o, inst_valid_o, stallreq_o
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
//============================================================================
// Module   : if_fetch
// Brief    : Byte-serial instruction fetch; assembles a little-endian word.
// Revision : 1.0
//============================================================================
module if_fetch #(
    parameter int ADDR_W     = 32,
    parameter int INST_BYTES = 4
) (
    input  wire        clk,
    input  wire        rst,
    if_fetch_if.master bus
);
    localparam int                 c_cnt_w  = $clog2(INST_BYTES + 1);
    localparam int                 c_inst_w = 8 * INST_BYTES;
    localparam logic [c_cnt_w-1:0] c_nbytes = c_cnt_w'(INST_BYTES);
    localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_fetch = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [ADDR_W-1:0]   r_base;
    logic [c_cnt_w-1:0]  r_req_cnt;
    logic [c_cnt_w-1:0]  r_rcv_cnt;
    logic [c_inst_w-1:0] r_buf;
    logic [c_inst_w-1:0] w_buf_nxt;
    logic [c_inst_w-1:0] r_inst;
    logic [ADDR_W-1:0]   r_inst_pc;
    logic                r_inst_valid;

    logic w_in_fetch;
    logic w_issue;
    logic w_take;
    logic w_last;
    logic w_flush;
    logic w_consume;

    assign w_flush    = bus.branch_flush_i;
    assign w_in_fetch = (r_state == c_st_fetch);
    // Requests are suppressed during reset so the memory never sees a fetch we will discard.
    assign w_issue    = w_in_fetch && !rst && !bus.mem_busy_i && (r_req_cnt < c_nbytes);
    assign w_take     = w_in_fetch && bus.mem_rvalid_i;
    assign w_last     = w_take && (r_rcv_cnt == (c_nbytes - c_one));
    assign w_consume  = (r_state == c_st_done) && !bus.stall_i;

    genvar gi;
    generate
        for (gi = 0; gi < INST_BYTES; gi++) begin : g_byte_lane
            assign w_buf_nxt[8*gi +: 8] = (w_take && (r_rcv_cnt == c_cnt_w'(gi)))
                                          ? bus.mem_rdata_i : r_buf[8*gi +: 8];
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a flush wins over completion and over a downstream stall
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (!w_flush) begin
                    w_state_nxt = c_st_fetch;
                end
            end
            c_st_fetch: begin
                if (w_flush) begin
                    w_state_nxt = c_st_idle;
                end else if (w_last) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                if (w_flush || !bus.stall_i) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Output logic
    always_comb begin
        bus.mem_req_o  = w_issue;
        bus.mem_addr_o = '0;
        if (w_issue) begin
            bus.mem_addr_o = r_base + ADDR_W'(r_req_cnt);
        end
        bus.stallreq_o = (r_state != c_st_done);
    end

    assign bus.inst_o       = r_inst;
    assign bus.inst_pc_o    = r_inst_pc;
    assign bus.inst_valid_o = r_inst_valid;

    // Fetch datapath: base latch, counters, byte assembly and IF/ID output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base       <= '0;
            r_req_cnt    <= '0;
            r_rcv_cnt    <= '0;
            r_buf        <= '0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_req_cnt <= '0;
                    r_rcv_cnt <= '0;
                    if (!w_flush) begin
                        r_base <= bus.pc_i;
                    end
                end
                c_st_fetch: begin
                    if (w_flush) begin
                        r_req_cnt <= '0;
                        r_rcv_cnt <= '0;
                    end else begin
                        if (w_issue) begin
                            r_req_cnt <= r_req_cnt + c_one;
                        end
                        if (w_take) begin
                            r_rcv_cnt <= r_rcv_cnt + c_one;
                        end
                        r_buf <= w_buf_nxt;
                        if (w_last) begin
                            r_inst       <= w_buf_nxt;
                            r_inst_pc    <= r_base;
                            r_inst_valid <= 1'b1;
                        end
                    end
                end
                c_st_done: begin
                    if (w_flush || w_consume) begin
                        r_inst_valid <= 1'b0;
                        r_req_cnt    <= '0;
                        r_rcv_cnt    <= '0;
                    end
                end
                default: begin
                    r_inst_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
